// File: rtl/nibble_addsub_seq.sv
// 11-bit signed add/subtract sequencer that time-shares one 4-bit carry-lookahead
// slice across three LSB-first nibble passes, with a registered carry between passes.

module cla (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g    = a & b;
    assign p    = a ^ b;
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);
    assign sum  = p ^ c[3:0];
    assign cout = c[4];
endmodule

module nibble_addsub_seq (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START,
    input  logic        OP,
    input  logic [10:0] A,
    input  logic [10:0] B,
    output logic        BUSY,
    output logic        DONE,
    output logic [10:0] RESULT,
    output logic        OVF
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD0,
        S_ADD1,
        S_ADD2,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        accept;
    logic [11:0] op_a;
    logic [11:0] op_b;
    logic        carry;
    logic [7:0]  partial;
    logic [10:0] result_q;
    logic        ovf_q;
    logic [3:0]  nib_a;
    logic [3:0]  nib_b;
    logic [3:0]  nib_sum;
    logic        nib_cout;
    logic [11:0] sum_full;

    assign accept = START && (state == S_IDLE || state == S_DONE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= S_IDLE;
        else        state <= state_next;
    end

    // NOTE: defaulting state_next first keeps this block free of inferred latches.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: state_next = START ? S_ADD0 : S_IDLE;
            S_ADD0:         state_next = S_ADD1;
            S_ADD1:         state_next = S_ADD2;
            S_ADD2:         state_next = S_DONE;
            default:        state_next = S_IDLE;
        endcase
    end

    always_comb begin
        BUSY = 1'b0;
        DONE = 1'b0;
        case (state)
            S_ADD0, S_ADD1, S_ADD2: BUSY = 1'b1;
            S_DONE:                 DONE = 1'b1;
            default:                ;
        endcase
    end

    assign RESULT = result_q;
    assign OVF    = ovf_q;

    // Operand nibble mux in front of the shared slice.
    always_comb begin
        nib_a = op_a[3:0];
        nib_b = op_b[3:0];
        case (state)
            S_ADD1: begin
                nib_a = op_a[7:4];
                nib_b = op_b[7:4];
            end
            S_ADD2: begin
                nib_a = op_a[11:8];
                nib_b = op_b[11:8];
            end
            default: ;
        endcase
    end

    cla u_cla (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // Nibble 2 never needs storing: it goes straight into RESULT/OVF on the same edge.
    assign sum_full = {nib_sum, partial};

    // NOTE: datapath registers are small flops, so they are reset along with the FSM.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            op_a     <= '0;
            op_b     <= '0;
            carry    <= 1'b0;
            partial  <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        op_a  <= {A[10], A};
                        op_b  <= OP ? ~{B[10], B} : {B[10], B};
                        carry <= OP;
                    end
                end
                S_ADD0: begin
                    partial[3:0] <= nib_sum;
                    carry        <= nib_cout;
                end
                S_ADD1: begin
                    partial[7:4] <= nib_sum;
                    carry        <= nib_cout;
                end
                S_ADD2: begin
                    carry    <= nib_cout;
                    result_q <= sum_full[10:0];
                    ovf_q    <= sum_full[11] ^ sum_full[10];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/nibble_addsub_seq.md
# nibble_addsub_seq

Multi-cycle 11-bit signed add/subtract sequencer that time-shares a single 4-bit carry-lookahead adder slice (`cla`: `A[3:0]`, `B[3:0]`, `CIN` -> `SUM[3:0]`, `COUT`) across three nibble passes. It sits between the calculator's operand/opcode front end and its result display. It replaces a full-width adder with one slice, a carry register and a small FSM. It accepts a start pulse, runs the nibbles LSB-first, and returns an 11-bit two's-complement result with an overflow flag.

## Interface
- Parameters: none. Width is fixed at 11 bits (3 nibbles after sign extension to 12 bits).
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST_N` in 1: reset, asynchronous, active-low.
- `START` in 1: request. Sampled only in IDLE or DONE.
- `OP` in 1: 0 = A+B, 1 = A−B. Sampled with START.
- `A` in 11: signed operand. Sampled with START.
- `B` in 11: signed operand. Sampled with START.
- `BUSY` out 1: high while a nibble pass is in progress (states ADD0–ADD2).
- `DONE` out 1: one-cycle pulse when RESULT/OVF update.
- `RESULT` out 11: signed result. Held until the next completion.
- `OVF` out 1: signed overflow of the 11-bit result. Held with RESULT.

## Operation
- FSM states: IDLE, ADD0, ADD1, ADD2, DONE.
  - IDLE/DONE + START -> ADD0.
  - IDLE/DONE without START -> IDLE.
  - ADD0 -> ADD1 -> ADD2 -> DONE, unconditional.
- Accept (START=1 in IDLE or DONE):
  - opA <= sign-extend(A) to 12 bits.
  - opB <= sign-extend(B) to 12 bits, bitwise inverted if OP=1.
  - carry register <= OP.
- ADDn (n = 0, 1, 2): the single `cla` instance is driven with:
  - A = opA[4n+3:4n], B = opB[4n+3:4n], CIN = carry register.
  - At the clock edge: partial[4n+3:4n] <= SUM and carry <= COUT.
- Leaving ADD2:
  - RESULT <= sum[10:0].
  - OVF <= sum[11] XOR sum[10], where sum is the 12-bit partial register including the nibble-2 write.
  - The final COUT is discarded.
- Arithmetic: 12-bit two's complement. The exact result of two 11-bit signed operands always fits in 12 bits, so the OVF rule is exact for both add and subtract, including B = −1024 with OP=1.
- START while BUSY is ignored. Operands and OP are not re-sampled mid-operation.
- Back-to-back operation: START held or re-asserted during DONE is accepted in that same cycle.
- RESULT and OVF change only on the ADD2->DONE transition. They stay stable throughout a subsequent operation.
- Outputs:
  - BUSY = (state is ADD0, ADD1 or ADD2).
  - DONE = (state == DONE).
  - Both are decoded from registered state; no combinational path from inputs.

## Timing
- Reset (RST_N=0, any time, including mid-operation):
  - State = IDLE.
  - BUSY = 0, DONE = 0, RESULT = 0, OVF = 0.
  - Carry and operand/partial registers are cleared.
  - An in-flight operation is abandoned, with no DONE.
- Let E0 be the edge sampling START=1:
  - BUSY is high for the cycles E0–E3.
  - Nibble 0, 1 and 2 are computed at E1, E2 and E3 respectively.
  - At E3, RESULT/OVF update and DONE=1 for the single cycle E3–E4.
- Latency from START edge to DONE assertion: 3 cycles. Result valid from the same edge as DONE.
- Throughput:
  - One operation per 4 cycles with START re-asserted in DONE.
  - 5 cycles if the requester waits for IDLE.
- Critical path: one 4-bit CLA plus the operand mux. The carry is registered between nibbles.

## Test plan
- A=100, B=23, OP=0, START pulse:
  - BUSY high 3 cycles.
  - DONE exactly 3 cycles after the START edge.
  - RESULT=0x07B (123), OVF=0.
- A=5, B=7, OP=1 -> RESULT=0x7FE (−2), OVF=0.
- Overflow cases:
  - A=1023, B=1, OP=0 -> RESULT=0x400, OVF=1.
  - A=−1024 (0x400), B=1, OP=1 -> RESULT=0x3FF, OVF=1.
  - A=−1024, B=−1024, OP=1 -> RESULT=0x000, OVF=0.
- Operand capture and back-to-back:
  - Start A=10, B=3, OP=0.
  - During BUSY, change A/B/OP and pulse START: the pulse is ignored and RESULT=13.
  - Assert START in DONE with A=−1, B=−1, OP=0: accepted; next DONE 3 cycles later with RESULT=0x7FE.
  - RESULT holds 13 until then.
- Reset mid-operation:
  - Pulse RST_N low during ADD1 of 200+300: BUSY/DONE/RESULT/OVF = 0 immediately, no DONE follows.
  - After release, 200+300 runs normally -> RESULT=0x1F4 (500).
- Random sweep of 10k (A, B, OP) triples against a reference model: RESULT and OVF match every time, and DONE pulses exactly once per accepted START.
